// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode receiver: frame FSM states,
// prefix byte constants, the decoded key event layout and a parity helper.
package ps2_pkg;

   // Frame reception states, one per field of the 11-bit PS/2 frame
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
   localparam int         PS2_EVT_W      = 10;

   // One decoded key event as stored in the FIFO
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   // PS/2 uses odd parity: the 8 data bits plus the parity bit hold an odd
   // number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   // Prefix bytes only modify the flags of the following key code
   function automatic logic is_prefix(input logic [7:0] code);
      return (code == PS2_EXT_PREFIX) || (code == PS2_BRK_PREFIX);
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one raw
// PS/2 pin. The filtered level only follows the pin once FILT_LEN identical
// synchronised samples that differ from it have been seen in a row. Both the
// synchroniser and the filter leave reset high, matching an idle bus.
module ps2_sync_filter
   import ps2_pkg::*;
#(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic value
);

   localparam int               CNT_W    = $clog2(FILT_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] run_cnt;

   // Bring the asynchronous pin into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Count consecutive samples that disagree with the filtered level; any
   // agreeing sample restarts the run, so short glitches never get through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value   <= 1'b1;
         run_cnt <= '0;
      end else if (sync2 != value) begin
         if (run_cnt == CNT_LAST) begin
            value   <= sync2;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end else begin
         run_cnt <= '0;
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, checks each 11-bit frame
// (start, 8 data LSB first, odd parity, stop), folds E0/F0 prefixes into
// ext/brk flags and queues {ext, brk, code} events in a show-ahead FIFO.
// Build option PS2_TIMEOUT_EN adds an abort of partial frames after
// TIMEOUT_CYC clocks without a PS/2 clock falling edge.
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILT_LEN    = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   output logic [PS2_EVT_W-1:0]          rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          overflow,
   input  logic                          clr_err
);

   localparam int                AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]       LVL_FULL  = (AW + 1)'(FIFO_DEPTH);

   // ---------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------
   logic clk_filt;
   logic data_filt;
   logic clk_filt_prev;
   logic strobe;

   ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .din   (ps2_clk),
      .value (clk_filt)
   );

   ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_data_filter (
      .clk   (clk),
      .rst   (rst),
      .din   (ps2_data),
      .value (data_filt)
   );

   // Remember the previous filtered clock to detect its falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) clk_filt_prev <= 1'b1;
      else     clk_filt_prev <= clk_filt;
   end

   // Single-cycle strobe in the first cycle the filtered clock reads low
   assign strobe = clk_filt_prev & ~clk_filt;

   // ---------------------------------------------------------------------
   // Frame FSM, prefix flags and error pulses
   // ---------------------------------------------------------------------
   ps2_state_t state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       par_bit;
   logic       byte_done;
   logic       ext;
   logic       brk;
   logic       timeout;
   logic       par_ok;

   assign par_ok = odd_parity_ok(shift, par_bit);

   // Walk through the frame one filtered clock fall at a time; the prefix
   // flags live here too because errors and timeouts must clear them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         par_bit    <= 1'b0;
         byte_done  <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
         ext        <= 1'b0;
         brk        <= 1'b0;
      end else begin
         byte_done  <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;

         // The byte finished last cycle is decoded now, alongside the push
         if (byte_done) begin
            if (shift == PS2_EXT_PREFIX) begin
               ext <= 1'b1;
            end else if (shift == PS2_BRK_PREFIX) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end

         if (timeout) begin
            state     <= IDLE;
            err_frame <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
         end else if (strobe) begin
            case (state)
               IDLE: begin
                  // A high start bit is line noise, not a frame
                  if (!data_filt) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift   <= {data_filt, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_bit <= data_filt;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (par_ok && data_filt) byte_done <= 1'b1;
                  if (!par_ok) begin
                     err_parity <= 1'b1;
                     ext        <= 1'b0;
                     brk        <= 1'b0;
                  end
                  if (!data_filt) begin
                     err_frame <= 1'b1;
                     ext       <= 1'b0;
                     brk       <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef PS2_TIMEOUT_EN
   localparam int               TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] to_cnt;

   // Measure the quiet time since the last strobe of an unfinished frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            to_cnt <= '0;
      else if (state == IDLE || strobe)   to_cnt <= '0;
      else                                to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (state != IDLE) && !strobe && (to_cnt == TO_LAST);
`else
   // Without the option a partial frame simply waits for more edges
   assign timeout = (TIMEOUT_CYC < 0);
`endif

   // ---------------------------------------------------------------------
   // Event FIFO
   // ---------------------------------------------------------------------
   ps2_evt_t        mem [FIFO_DEPTH];
   ps2_evt_t        evt;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            push;
   logic            pop;
   logic            full;
   logic            wr_ok;

   assign evt   = '{ext: ext, brk: brk, code: shift};
   assign push  = byte_done && !is_prefix(shift);
   assign pop   = rd_en && (count != '0);
   assign full  = (count == LVL_FULL);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign wr_ok = push && (!full || pop);

   // Storage carries no reset; only pointers and count define validity
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= evt;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at AW bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky drop flag; a new drop outranks a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      overflow <= 1'b0;
      else if (push && full && !pop) overflow <= 1'b1;
      else if (clr_err)             overflow <= 1'b0;
   end

   assign rd_valid   = (count != '0);
   assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
   assign fifo_level = count;

endmodule
